hello_world: RTL and testbench
==============================

// Module: hello_world
// PURPOSE
//  Transmits the fixed 15-byte ASCII message "Hello, world!\r\n" over a UART line on request.
//  - Self-contained demo/bring-up block: a trigger input starts one full message.
//  - Drives a board-level serial TX pin directly; a busy flag reports transmission in progress.
//  - Contains its own message ROM, byte sequencer and UART transmitter.
// PARAMETERS
//  CLOCK_RATE      100_000_000  clk frequency in Hz
//  BAUD_RATE       115_200      serial bit rate in bit/s
//  CLOCKS_PER_BIT  CLOCK_RATE/BAUD_RATE (=868, integer division)  clk cycles per serial bit
// PORTS
//  clk      in   1  single clock; all logic on rising edge
//  rst      in   1  synchronous, active-high reset
//  trigger  in   1  level; high while idle starts one message
//  busy     out  1  high from message start until the final stop bit completes
//  tx       out  1  UART serial data, idle high
// BEHAVIOUR
//  - Reset: on any clk edge with rst=1, tx<=1, busy<=0, state<=IDLE, byte index<=0.
//    rst overrides everything, including mid-message; transmission aborts and the next
//    message restarts from 'H'.
//  - Frame format: 8N1, LSB first. One start bit (0), eight data bits, one stop bit (1).
//    Each bit is held for exactly CLOCKS_PER_BIT cycles, giving 8680 cycles per byte.
//  - Message: bytes 0..14 = 48 65 6C 6C 6F 2C 20 77 6F 72 6C 64 21 0D 0A.
//    Bytes are sent back-to-back with no idle gap between stop bit and next start bit.
//    Total message length is 15*8680 = 130200 cycles.
//  - Start: trigger sampled 1 in IDLE (and rst=0) -> next cycle busy=1 and tx=0 (start bit of byte 0).
//    Latency from trigger to start bit is 1 cycle.
//  - trigger while busy=1 is ignored; no queuing.
//    If trigger is still high when the message ends, a new message starts on the first cycle
//    back in IDLE.
//  - Completion: after the final byte's stop bit has lasted CLOCKS_PER_BIT cycles, busy<=0 and
//    tx stays 1.
//  - Sequencer FSM states, with transitions:
//    - IDLE -> SEND on trigger.
//    - SEND -> IDLE when the byte with index 14 completes.
//    - In SEND: advance the index and load the next byte on the UART done/ready pulse.
//  - UART TX FSM states: IDLE, START, DATA (3-bit bit counter 0..7), STOP.
//    - Baud counter width is $clog2(CLOCKS_PER_BIT); it counts 0..CLOCKS_PER_BIT-1 and
//      wraps to 0 on each bit boundary.
//  - Outputs are registered, so tx is glitch-free.
//  - Byte index is 4 bits, range 0..14; it never reaches 15.
// STRUCTURE
//  - serial_pkg: CLOCK_RATE/BAUD_RATE defaults, the message length constant MSG_LEN=15,
//    and the typedefs for the sequencer and UART state enums.
//  - Sub-module uart_tx (clk, rst, send, data[7:0], busy, tx):
//    - Accepts data when send=1 and it is not busy.
//    - Asserts a one-cycle done pulse at the end of the stop bit.
//  - hello_world holds the message ROM (case or constant array) and the sequencer FSM,
//    and instantiates uart_tx.
// TESTING
//  1. Reset: rst=1 for 4 cycles -> tx=1 and busy=0 throughout, and also for 4 cycles after
//     release.
//  2. Single trigger (2-cycle pulse) -> the following all hold:
//     - busy rises 1 cycle later.
//     - A UART decoder sampling mid-bit at 868 cycles/bit receives exactly
//       "Hello, world!\r\n".
//     - busy falls 130200 cycles after it rose.
//  3. Re-trigger: trigger pulse 40 ns after busy falls -> the complete message is sent again,
//     identical.
//  4. Trigger held/pulsed during busy -> no disturbance of the bit stream; busy stays 1
//     continuously until the end of the message.
//  5. Mid-message reset during byte 3 -> tx=1 and busy=0 on the next edge.
//     A subsequent trigger then sends the full message starting from 'H' (0x48).
//  6. Bit timing: the start bit of byte 0 lasts exactly 868 cycles.
//     The stop bit of byte 0 is immediately followed by the start bit of byte 1 (0x65).

Source files
------------

// File: rtl/serial_pkg.sv
// Shared constants, state types and the message ROM for the hello_world UART demo.
package serial_pkg;

  localparam int CLOCK_RATE_DEF = 100_000_000;
  localparam int BAUD_RATE_DEF  = 115_200;
  localparam int MSG_LEN        = 15;

  typedef enum logic {
    SEQ_IDLE,
    SEQ_SEND
  } seq_state_t;

  typedef enum logic [1:0] {
    UART_IDLE,
    UART_START,
    UART_DATA,
    UART_STOP
  } uart_state_t;

  // "Hello, world!\r\n"; out-of-range indices read as zero and are never used.
  function automatic logic [7:0] msg_byte(input logic [3:0] idx);
    logic [7:0] b;
    case (idx)
      4'd0:    b = 8'h48;
      4'd1:    b = 8'h65;
      4'd2:    b = 8'h6C;
      4'd3:    b = 8'h6C;
      4'd4:    b = 8'h6F;
      4'd5:    b = 8'h2C;
      4'd6:    b = 8'h20;
      4'd7:    b = 8'h77;
      4'd8:    b = 8'h6F;
      4'd9:    b = 8'h72;
      4'd10:   b = 8'h6C;
      4'd11:   b = 8'h64;
      4'd12:   b = 8'h21;
      4'd13:   b = 8'h0D;
      4'd14:   b = 8'h0A;
      default: b = 8'h00;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/uart_tx.sv
// 8N1 LSB-first UART transmitter; a new byte may be accepted on the last stop-bit
// cycle so consecutive frames run back-to-back.
module uart_tx
  import serial_pkg::*;
#(
  parameter int CLOCKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       send,
  input  logic [7:0] data,
  output logic       busy,
  output logic       tx,
  output logic       done
);

  localparam int               CNT_W   = (CLOCKS_PER_BIT > 1) ? $clog2(CLOCKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLOCKS_PER_BIT - 1);

  uart_state_t      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic             tx_q, tx_d;
  logic             bit_end;
  logic             accept;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    bit_end = (cnt_q == CNT_MAX);
    done    = (state_q == UART_STOP) && bit_end;
    accept  = send && ((state_q == UART_IDLE) || done);

    if (state_q != UART_IDLE) begin
      cnt_d = bit_end ? '0 : cnt_q + 1'b1;
    end

    case (state_q)
      UART_IDLE: begin
        tx_d = 1'b1;
      end
      UART_START: begin
        if (bit_end) begin
          state_d = UART_DATA;
          bit_d   = 3'd0;
          tx_d    = shift_q[0];
        end
      end
      UART_DATA: begin
        if (bit_end) begin
          if (bit_q == 3'd7) begin
            state_d = UART_STOP;
            tx_d    = 1'b1;
          end else begin
            // tx already shows shift_q[0]; present the next bit and shift it down.
            bit_d   = bit_q + 3'd1;
            shift_d = {1'b0, shift_q[7:1]};
            tx_d    = shift_q[1];
          end
        end
      end
      UART_STOP: begin
        if (bit_end) begin
          state_d = UART_IDLE;
          tx_d    = 1'b1;
        end
      end
      default: begin
        state_d = UART_IDLE;
        tx_d    = 1'b1;
      end
    endcase

    if (accept) begin
      state_d = UART_START;
      cnt_d   = '0;
      bit_d   = 3'd0;
      shift_d = data;
      tx_d    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= UART_IDLE;
      cnt_q   <= '0;
      bit_q   <= 3'd0;
      shift_q <= 8'h00;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
    end
  end

  assign busy = (state_q != UART_IDLE);
  assign tx   = tx_q;

endmodule

// File: rtl/hello_world.sv
// Sends "Hello, world!\r\n" over a UART line once per trigger while idle;
// busy covers the whole message.
module hello_world
  import serial_pkg::*;
#(
  parameter int CLOCK_RATE = CLOCK_RATE_DEF,
  parameter int BAUD_RATE  = BAUD_RATE_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic trigger,
  output logic busy,
  output logic tx
);

  localparam int         CLOCKS_PER_BIT = CLOCK_RATE / BAUD_RATE;
  localparam logic [3:0] LAST_IDX       = 4'(MSG_LEN - 1);

  seq_state_t state_q, state_d;
  logic [3:0] idx_q, idx_d;
  logic       busy_q, busy_d;
  logic [3:0] rom_idx;
  logic       send;
  logic       uart_busy;
  logic       uart_done;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    busy_d  = busy_q;
    send    = 1'b0;
    rom_idx = idx_q;

    case (state_q)
      SEQ_IDLE: begin
        if (trigger && !uart_busy) begin
          state_d = SEQ_SEND;
          idx_d   = 4'd0;
          busy_d  = 1'b1;
          send    = 1'b1;
          rom_idx = 4'd0;
        end
      end
      SEQ_SEND: begin
        // The done pulse is the last stop-bit cycle, so the next byte starts with no gap.
        if (uart_done) begin
          if (idx_q == LAST_IDX) begin
            state_d = SEQ_IDLE;
            idx_d   = 4'd0;
            busy_d  = 1'b0;
          end else begin
            idx_d   = idx_q + 4'd1;
            send    = 1'b1;
            rom_idx = idx_q + 4'd1;
          end
        end
      end
      default: begin
        state_d = SEQ_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= SEQ_IDLE;
      idx_q   <= 4'd0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      busy_q  <= busy_d;
    end
  end

  uart_tx #(
    .CLOCKS_PER_BIT(CLOCKS_PER_BIT)
  ) u_uart_tx (
    .clk  (clk),
    .rst  (rst),
    .send (send),
    .data (msg_byte(rom_idx)),
    .busy (uart_busy),
    .tx   (tx),
    .done (uart_done)
  );

  assign busy = busy_q;

endmodule

// File: tb/tb_hello_world.sv
// Directed bench for hello_world at 16 clocks per bit: decodes the serial stream,
// checks busy timing, re-trigger, trigger-during-busy and mid-message reset.
module tb_hello_world;

  localparam int CPB     = 16;
  localparam int MSG_CYC = 150 * CPB;

  logic clk;
  logic rst;
  logic trigger;
  logic busy;
  logic tx;

  int total;
  int bad;
  int cyc;

  logic [7:0] msg [15] = '{8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F, 8'h2C, 8'h20, 8'h77,
                           8'h6F, 8'h72, 8'h6C, 8'h64, 8'h21, 8'h0D, 8'h0A};

  hello_world #(
    .CLOCK_RATE(1_600_000),
    .BAUD_RATE (100_000)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .trigger(trigger),
    .busy   (busy),
    .tx     (tx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at cycle %0d", tag, got, exp, cyc);
    end
  endtask

  // Expected line level at a given cycle offset from the first start bit.
  function automatic logic exp_tx(input int off);
    int byte_i;
    int bit_i;
    logic [7:0] b;
    byte_i = off / (10 * CPB);
    bit_i  = (off % (10 * CPB)) / CPB;
    if (byte_i >= 15) return 1'b1;
    if (bit_i == 0) return 1'b0;
    if (bit_i == 9) return 1'b1;
    b = msg[byte_i];
    return b[bit_i-1];
  endfunction

  task automatic rx_byte(output logic [7:0] b);
    int n;
    n = 0;
    b = 8'h00;
    while (tx !== 1'b0 && n < 12 * CPB) begin
      @(negedge clk);
      n++;
    end
    if (tx !== 1'b0) begin
      check("rx_start_found", 32'(tx), 32'd0);
      return;
    end
    repeat (CPB / 2) @(negedge clk);
    check("rx_start_mid", 32'(tx), 32'd0);
    for (int i = 0; i < 8; i++) begin
      repeat (CPB) @(negedge clk);
      b[i] = tx;
    end
    repeat (CPB) @(negedge clk);
    check("rx_stop_mid", 32'(tx), 32'd1);
  endtask

  task automatic run_msg(input int pulse_len);
    logic [7:0] b;
    int rise;
    int n;
    @(negedge clk);
    trigger = 1'b1;
    check("pre_busy", 32'(busy), 32'd0);
    @(negedge clk);
    check("busy_rise", 32'(busy), 32'd1);
    check("start_tx", 32'(tx), 32'd0);
    rise = cyc;
    if (pulse_len > 1) begin
      fork
        begin
          @(negedge clk);
          trigger = 1'b0;
        end
      join_none
    end else begin
      trigger = 1'b0;
    end
    for (int i = 0; i < 15; i++) begin
      rx_byte(b);
      check($sformatf("rx_byte%0d", i), 32'(b), 32'(msg[i]));
      $display("rx byte %0d = %02h", i, b);
    end
    n = 0;
    while (busy && n < 4 * CPB) begin
      @(negedge clk);
      n++;
    end
    check("busy_len", 32'(cyc - rise), 32'(MSG_CYC));
    check("idle_tx", 32'(tx), 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    total   = 0;
    bad     = 0;
    rst     = 1'b1;
    trigger = 1'b0;

    // Reset held then released: line idle, not busy.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("rst_tx", 32'(tx), 32'd1);
      check("rst_busy", 32'(busy), 32'd0);
    end
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("post_rst_tx", 32'(tx), 32'd1);
      check("post_rst_busy", 32'(busy), 32'd0);
    end

    $display("msg 1: 2-cycle trigger");
    run_msg(2);

    $display("msg 2: re-trigger 40 ns after busy falls");
    repeat (3) @(negedge clk);
    run_msg(1);

    $display("msg 3: trigger toggled while busy, full waveform compare");
    repeat (2) @(negedge clk);
    trigger = 1'b1;
    @(negedge clk);
    check("wave_busy_rise", 32'(busy), 32'd1);
    for (int off = 0; off < MSG_CYC; off++) begin
      check("wave_tx", 32'(tx), 32'(exp_tx(off)));
      check("wave_busy", 32'(busy), 32'd1);
      if (off == CPB - 1)      check("start0_last", 32'(tx), 32'd0);
      if (off == 4 * CPB)      check("h_bit3", 32'(tx), 32'd1);
      if (off == 10 * CPB - 1) check("stop0_last", 32'(tx), 32'd1);
      if (off == 10 * CPB)     check("start1_first", 32'(tx), 32'd0);
      if (off == 11 * CPB - 1) check("start1_last", 32'(tx), 32'd0);
      if (off == 11 * CPB)     check("e_bit0", 32'(tx), 32'd1);
      trigger = (off < MSG_CYC - 3) ? 1'($urandom_range(0, 1)) : 1'b0;
      @(negedge clk);
    end
    check("wave_busy_fall", 32'(busy), 32'd0);
    check("wave_end_tx", 32'(tx), 32'd1);
    @(negedge clk);
    check("no_restart_busy", 32'(busy), 32'd0);

    $display("msg 4: reset during byte 3, then full message");
    @(negedge clk);
    trigger = 1'b1;
    @(negedge clk);
    trigger = 1'b0;
    repeat (31 * CPB + CPB / 2) @(negedge clk);
    check("pre_rst_tx", 32'(tx), 32'd0);
    check("pre_rst_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_tx", 32'(tx), 32'd1);
    check("mid_rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("after_rst_busy", 32'(busy), 32'd0);
    check("after_rst_tx", 32'(tx), 32'd1);
    run_msg(1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
